fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the Chronos RV32I core. Owns the PC and drives inst_mem
//  (fetch_addr/fetch_req in, request_data back combinationally, same cycle). Buffers fetched
//  words in a small queue and hands them to decode over a valid/ready handshake.
//  Handles start, halt, and branch/jump redirects from execute.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; must be word aligned
//  QDEPTH      2              instruction queue entries; power of two, >=2
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  start          in   1   pulse: leave IDLE and begin fetching
//  halt           in   1   level: suspend fetching while high
//  fetch_addr     out  32  byte address to inst_mem (always = pc)
//  fetch_req      out  1   fetch strobe to inst_mem
//  request_data   in   32  instruction word from inst_mem, valid in the cycle fetch_req=1
//  inst_valid     out  1   queue head is valid
//  inst_ready     in   1   decode accepts the head this cycle
//  inst_data      out  32  queue-head instruction
//  inst_pc        out  32  queue-head PC
//  redirect_valid in   1   execute redirects fetch (taken branch/jump)
//  redirect_addr  in   32  new PC
//  misalign_err   out  1   sticky: redirect target not word aligned
//  err_addr       out  32  offending redirect_addr, captured on error
//  busy           out  1   state==RUN || inst_valid
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, count=0, misalign_err=0, err_addr=0.
//   This gives fetch_req=0 and inst_valid=0. inst_data/inst_pc read 0 while the queue is empty.
//  States: IDLE, RUN, HALT, ERR (2-bit encoding, from the shared package).
//   IDLE->RUN on start. RUN->HALT while halt=1. HALT->RUN when halt=0.
//   Any state except ERR goes to ERR on a redirect with redirect_addr[1:0]!=0.
//   ERR is left only by reset. start while already in RUN/HALT is ignored.
//  fetch_req = (state==RUN) && !halt && (count<QDEPTH) && !redirect_valid.
//  Fetch: when fetch_req=1, push {pc, request_data} at the clock edge and set pc<=pc+4.
//   pc is 32-bit and wraps 32'hFFFF_FFFC -> 0 silently.
//  Latency: a word fetched in cycle N appears at the head (inst_valid=1) in cycle N+1.
//   There is no same-cycle bypass.
//  Pop: inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
//   Sustained throughput is 1 instruction/cycle.
//  Full: with count==QDEPTH and no pop, fetch_req=0 and pc holds. A pop this cycle does not
//   re-enable fetch until the next cycle (no full-bypass).
//  Empty: inst_valid=0. inst_ready is ignored.
//  Redirect has priority over fetch and pop.
//   Aligned target: queue flushed (count<=0), pc<=redirect_addr, state unchanged.
//    Applies in IDLE/HALT as well; an IDLE pc is set without fetching.
//   A head handshake in the redirect cycle is void; decode treats it as wrong-path.
//   Misaligned target: flush, pc unchanged, misalign_err<=1, err_addr<=redirect_addr, ERR.
//  ERR and HALT: no fetches. In ERR the queue is already empty.
//   In HALT, entries present still drain to decode.
//  halt and redirect in the same cycle: redirect applied, then state goes to HALT.
//  Reset mid-stream: queue contents are dropped and nothing is replayed.
// STRUCTURE
//  chronos_pkg (shared): XLEN=32, INST_NOP=32'h0000_0013, FETCH_* state encodings, PC_STEP=4.
//  Sub-module fetch_queue: synchronous FIFO, width 64 ({pc,inst}), depth QDEPTH.
//   Ports: push, pop, flush, full, empty, count.
//   flush has priority over push and pop.
//  fetch_ctrl holds the state register, pc, error capture, and the fetch_req/handshake logic.
// TESTING
//  1 Reset, start pulse, inst_ready=1, inst_mem preloaded with words W0..W3
//    -> fetch_addr 0,4,8,C on consecutive cycles; inst_pc 0,4,8,C one cycle later
//    with the matching inst_data.
//  2 inst_ready=0 after start -> exactly 2 pushes; fetch_req=0 with pc=8.
//    Raise ready -> heads 0,4 pop, then fetching resumes at 8.
//  3 Redirect to 32'h40 while queue holds PCs 4,8 and ready=1 -> the next inst_pc is 32'h40.
//    The PCs 4,8 never handshake after the redirect cycle.
//  4 Redirect to 32'h42 -> misalign_err=1, err_addr=32'h42, fetch_req=0 thereafter.
//    A later start is ignored; only rst clears the error.
//  5 halt=1 for 3 cycles mid-stream -> no fetch_req, queue drains.
//    halt=0 -> fetching resumes at the held pc with no gap or duplicate.
//  6 Assert rst asynchronously between edges while count=2
//    -> inst_valid=0 and fetch_req=0 immediately; pc=RESET_PC; state IDLE.

Source files
------------

// File: rtl/chronos_pkg.sv
// Shared definitions for the Chronos RV32I core: data width, canonical NOP,
// fetch-sequencer state encodings and the alignment helper used on redirects.
package chronos_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam logic [1:0] FETCH_IDLE = 2'b00;
  localparam logic [1:0] FETCH_RUN  = 2'b01;
  localparam logic [1:0] FETCH_HALT = 2'b10;
  localparam logic [1:0] FETCH_ERR  = 2'b11;

  // A fetch target is only legal on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instruction} pairs between fetch and
// decode. Flush wins over push and pop; the raw head entry is exposed as-is.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flushed slot is simply overwritten later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (!flush && push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, strobes inst_mem, buffers fetched
// words and presents them to decode. Redirects from execute override fetch
// and pop; a misaligned redirect target parks the sequencer in ERR.
module fetch_ctrl
  import chronos_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  output logic [31:0] fetch_addr,
  output logic        fetch_req,
  input  logic [31:0] request_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        misalign_err,
  output logic [31:0] err_addr,
  output logic        busy
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic          q_full_s, q_empty_s, q_pop_s;
  logic [CW-1:0] q_count_s;
  logic [63:0]   q_head_s;

  assign fetch_addr   = pc_q;
  assign misalign_err = err_q;
  assign err_addr     = err_addr_q;
  assign inst_valid   = (q_count_s != {CW{1'b0}});
  assign inst_pc      = q_empty_s ? 32'h0000_0000 : q_head_s[63:32];
  assign inst_data    = q_empty_s ? 32'h0000_0000 : q_head_s[31:0];
  assign busy         = (state_q == FETCH_RUN) || inst_valid;

  // Fetch strobe; a redirect cycle never fetches since the pc is stale.
  assign fetch_req = (state_q == FETCH_RUN) && !halt && !q_full_s && !redirect_valid;
  // A handshake coinciding with a redirect is wrong-path and not consumed.
  assign q_pop_s   = inst_valid && inst_ready && !redirect_valid;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_req),
    .pop   (q_pop_s),
    .flush (redirect_valid),
    .wdata ({pc_q, request_data}),
    .rdata (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s),
    .count (q_count_s)
  );

  // Next-state, pc and error-capture logic; redirects take priority.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (redirect_valid && (state_q != FETCH_ERR) && is_misaligned(redirect_addr)) begin
      state_d    = FETCH_ERR;
      err_d      = 1'b1;
      err_addr_d = redirect_addr;
    end else begin
      if (redirect_valid && (state_q != FETCH_ERR)) pc_d = redirect_addr;
      else if (fetch_req)                            pc_d = pc_q + PC_STEP;
      else                                           pc_d = pc_q;
      case (state_q)
        FETCH_IDLE: state_d = start ? FETCH_RUN : FETCH_IDLE;
        FETCH_RUN:  state_d = halt ? FETCH_HALT : FETCH_RUN;
        FETCH_HALT: state_d = halt ? FETCH_HALT : FETCH_RUN;
        FETCH_ERR:  state_d = FETCH_ERR;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  // Sequencer registers; reset drops everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table covers streaming, back-pressure,
// redirects, halt and the misalignment error; hand sequences cover the stall
// count, wrap-around, IDLE redirect and asynchronous reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt, inst_ready, redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] fetch_addr, request_data, inst_data, inst_pc, err_addr;
  logic        fetch_req, inst_valid, misalign_err, busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 + a;
  endfunction

  assign request_data = mem_word(fetch_addr);

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .fetch_addr     (fetch_addr),
    .fetch_req      (fetch_req),
    .request_data   (request_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .misalign_err   (misalign_err),
    .err_addr       (err_addr),
    .busy           (busy)
  );

  typedef struct {
    logic        st, ha, rd, rv;
    logic [31:0] raddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_ipc;
    logic        e_busy, e_err;
    logic [31:0] e_eaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic ha, input logic rd,
                       input logic rv, input logic [31:0] ra);
    start = st; halt = ha; inst_ready = rd; redirect_valid = rv; redirect_addr = ra;
  endtask

  // Hold reset over two edges, then release just after a rising edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic ha, input logic rd, input logic rv,
                     input logic [31:0] ra, input logic req, input logic [31:0] addr,
                     input logic val, input logic [31:0] ipc, input logic bsy,
                     input logic err, input logic [31:0] eaddr);
    vec_t v;
    v.st = st; v.ha = ha; v.rd = rd; v.rv = rv; v.raddr = ra;
    v.e_req = req; v.e_addr = addr; v.e_val = val; v.e_ipc = ipc;
    v.e_busy = bsy; v.e_err = err; v.e_eaddr = eaddr;
    tbl.push_back(v);
  endtask

  int pushes;

  initial begin
    //   st ha rd rv raddr        | req addr         val ipc          busy err eaddr
    add(1, 0, 1, 0, 32'h0,        0, 32'h00,       0, 32'h00,       0, 0, 32'h0);  // start in IDLE
    add(0, 0, 1, 0, 32'h0,        1, 32'h00,       0, 32'h00,       1, 0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        1, 32'h04,       1, 32'h00,       1, 0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        1, 32'h08,       1, 32'h04,       1, 0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        1, 32'h0C,       1, 32'h08,       1, 0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h0C,       1, 0, 32'h0);  // stall -> fills
    add(0, 0, 1, 0, 32'h0,        0, 32'h14,       1, 32'h0C,       1, 0, 32'h0);  // full, pop only
    add(0, 0, 1, 0, 32'h0,        1, 32'h14,       1, 32'h10,       1, 0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        1, 32'h18,       1, 32'h14,       1, 0, 32'h0);
    add(0, 0, 1, 1, 32'h40,       0, 32'h1C,       1, 32'h14,       1, 0, 32'h0);  // redirect
    add(0, 0, 1, 0, 32'h0,        1, 32'h40,       0, 32'h00,       1, 0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        1, 32'h44,       1, 32'h40,       1, 0, 32'h0);
    add(0, 1, 0, 0, 32'h0,        0, 32'h48,       1, 32'h44,       1, 0, 32'h0);  // halt
    add(0, 1, 1, 0, 32'h0,        0, 32'h48,       1, 32'h44,       1, 0, 32'h0);  // drains
    add(0, 1, 1, 0, 32'h0,        0, 32'h48,       0, 32'h00,       0, 0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h48,       0, 32'h00,       0, 0, 32'h0);  // HALT->RUN
    add(0, 0, 1, 0, 32'h0,        1, 32'h48,       0, 32'h00,       1, 0, 32'h0);  // resume at held pc
    add(0, 0, 1, 0, 32'h0,        1, 32'h4C,       1, 32'h48,       1, 0, 32'h0);
    add(0, 1, 1, 1, 32'h80,       0, 32'h50,       1, 32'h4C,       1, 0, 32'h0);  // halt+redirect
    add(0, 0, 1, 0, 32'h0,        0, 32'h80,       0, 32'h00,       0, 0, 32'h0);
    add(0, 0, 1, 0, 32'h0,        1, 32'h80,       0, 32'h00,       1, 0, 32'h0);
    add(0, 0, 1, 1, 32'h42,       0, 32'h84,       1, 32'h80,       1, 0, 32'h0);  // misaligned
    add(1, 0, 1, 0, 32'h0,        0, 32'h84,       0, 32'h00,       0, 1, 32'h42); // start ignored
    add(0, 0, 1, 0, 32'h0,        0, 32'h84,       0, 32'h00,       0, 1, 32'h42);

    // Reset values while rst is held.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #2;
    chk("rst_fetch_req",  {31'h0, fetch_req},  32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_fetch_addr", fetch_addr,          32'h0);
    chk("rst_inst_pc",    inst_pc,             32'h0);
    chk("rst_inst_data",  inst_data,           32'h0);
    chk("rst_err",        {31'h0, misalign_err}, 32'h0);
    chk("rst_err_addr",   err_addr,            32'h0);
    chk("rst_busy",       {31'h0, busy},       32'h0);

    // Table-driven stream.
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].ha, tbl[i].rd, tbl[i].rv, tbl[i].raddr);
      @(negedge clk);
      chk($sformatf("v%0d_fetch_req", i), {31'h0, fetch_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_fetch_addr", i), fetch_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].e_val});
      chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
      chk($sformatf("v%0d_inst_data", i), inst_data,
          tbl[i].e_val ? mem_word(tbl[i].e_ipc) : 32'h0);
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].e_busy});
      chk($sformatf("v%0d_err", i), {31'h0, misalign_err}, {31'h0, tbl[i].e_err});
      chk($sformatf("v%0d_err_addr", i), err_addr, tbl[i].e_eaddr);
      next_cycle();
    end

    // Only reset clears the sticky error.
    do_reset();
    #1;
    chk("err_cleared",      {31'h0, misalign_err}, 32'h0);
    chk("err_addr_cleared", err_addr,              32'h0);

    // Back-pressure from the start: exactly two pushes, then stall at pc 8.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pushes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fetch_req) pushes++;
      next_cycle();
    end
    chk("stall_pushes",    pushes,                 32'd2);
    chk("stall_fetch_req", {31'h0, fetch_req},     32'h0);
    chk("stall_pc",        fetch_addr,             32'h8);
    chk("stall_head_pc",   inst_pc,                32'h0);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("drain0_pc",  inst_pc,            32'h0);
    chk("drain0_req", {31'h0, fetch_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("drain1_pc",   inst_pc,            32'h4);
    chk("drain1_req",  {31'h0, fetch_req}, 32'h1);
    chk("drain1_addr", fetch_addr,         32'h8);
    next_cycle();
    @(negedge clk);
    chk("drain2_pc",   inst_pc,   32'h8);
    chk("drain2_data", inst_data, mem_word(32'h8));
    chk("drain2_addr", fetch_addr, 32'hC);

    // Redirect in IDLE sets pc without fetching; pc wraps at the top.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("idle_redir_req", {31'h0, fetch_req}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("idle_redir_pc",  fetch_addr,         32'hFFFF_FFFC);
    chk("idle_no_fetch",  {31'h0, fetch_req}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_fetch_top", fetch_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_fetch_zero", fetch_addr, 32'h0);
    chk("wrap_head_pc",    inst_pc,    32'hFFFF_FFFC);
    chk("wrap_head_data",  inst_data,  mem_word(32'hFFFF_FFFC));

    // Asynchronous reset between edges with two entries queued.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) next_cycle();
    chk("pre_arst_valid", {31'h0, inst_valid}, 32'h1);
    chk("pre_arst_pc",    fetch_addr,          32'h8);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid",     {31'h0, inst_valid}, 32'h0);
    chk("arst_fetch_req", {31'h0, fetch_req},  32'h0);
    chk("arst_pc",        fetch_addr,          32'h0);
    chk("arst_busy",      {31'h0, busy},       32'h0);
    next_cycle();
    rst = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("post_arst_idle_req", {31'h0, fetch_req},  32'h0);
    chk("post_arst_valid",    {31'h0, inst_valid}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
